inst_fetch_responder: RTL
=========================

// Module: inst_fetch_responder
// PURPOSE
//  Instruction-side responder for the IF stage. Takes the fetch pc and returns if_inst.
//  Holds IF with delay_hard while a fetch is outstanding.
//  Translates kseg0/kseg1 addresses and drives the SRAM-like instruction bus
//  (req / addr_ok / data_ok). Flags a misaligned pc (IADEE) and a bus timeout (IADFE).
// PARAMETERS
//  RESET_PC      32'hbfc0_0000  pc the buffer tag resets to (buffer invalid at reset)
//  TIMEOUT       16'd255        WAIT cycles without data_ok before a fetch fault
//  CNT_W         16             width of the timeout counter
// PORTS
//  clk           in   1   rising-edge clock
//  reset         in   1   asynchronous, active-high reset
//  pc            in   32  fetch address from IF (virtual)
//  if_cln        in   1   pipeline clean: invalidate buffer, abandon fetch
//  if_inst       out  32  instruction for pc (valid when delay_hard==0)
//  delay_hard    out  1   1 = no valid instruction for current pc; IF must hold
//  IADEE         out  1   pc[1:0]!=0 (address error), combinational
//  IADFE         out  1   fetch of current pc faulted (bus timeout)
//  inst_req      out  1   bus request
//  inst_addr     out  32  physical fetch address
//  inst_addr_ok  in   1   bus accepted address this cycle
//  inst_data_ok  in   1   read data valid this cycle
//  inst_rdata    in   32  read data
// BEHAVIOUR
//  - Translation: pc[31:30]==2'b10 -> {3'b000,pc[28:0]}; else pass through.
//  - Buffer: one entry {buf_valid, buf_pc, buf_inst, buf_fault}.
//    hit = buf_valid && buf_pc==pc.
//  - Outputs:
//    misaligned -> if_inst=0, delay_hard=0, IADEE=1, IADFE=0, no bus request.
//    else if_inst = hit ? buf_inst : 0; delay_hard = !hit; IADFE = hit && buf_fault.
//  - Reset: state IDLE, buf_valid=0, buf_pc=RESET_PC, buf_inst=0, buf_fault=0,
//    inst_req=0, inst_addr=0, counter=0. So delay_hard=1 and IADFE=0 right after reset.
//  - FSM (registered state; inst_req/inst_addr registered):
//    IDLE : !hit && !misaligned && !if_cln -> REQ. Latch req_pc=pc; inst_req<=1.
//    REQ  : hold inst_req=1, inst_addr=phys(req_pc).
//           If pc!=req_pc before addr_ok, retarget: req_pc<=pc, stay REQ.
//           On addr_ok: inst_req<=0 -> WAIT; counter<=0.
//           if_cln: drop req -> IDLE.
//    WAIT : counter++. On data_ok, if pc==req_pc and !if_cln: fill buffer
//           {1,req_pc,inst_rdata,0} -> IDLE.
//           pc!=req_pc or if_cln without data_ok -> DRAIN.
//           pc!=req_pc or if_cln in the same cycle as data_ok: discard data -> IDLE.
//           counter==TIMEOUT: fill {1,req_pc,32'h0,1} -> IDLE.
//    DRAIN: wait data_ok, discard -> IDLE. No new request until drained.
//  - Fetch latency, bus data_ok in cycle N after addr_ok:
//    buffer valid at edge N+1; IF sees delay_hard=0 from then on.
//    Minimum miss latency is 3 clocks from pc change.
//  - Any data_ok arriving in IDLE or REQ (late, after a timeout) is ignored.
//  - if_cln in any state clears buf_valid at that edge.
//  - Only one transaction is outstanding at any time.
// TESTING
//  1 Reset (pc=bfc00000): delay_hard=1, then inst_req=1 with inst_addr=1fc00000.
//    addr_ok at +1, data_ok+rdata=24010001 at +2 -> if_inst=24010001, delay_hard=0.
//  2 Hit: pc held at bfc00000 after fill -> no inst_req, if_inst stable, delay_hard=0.
//  3 Redirect in WAIT: pc -> bfc00380 before data_ok -> DRAIN.
//    Stale data discarded; new req with addr 1fc00380; correct inst returned.
//  4 Misaligned pc=bfc00002 -> IADEE=1, if_inst=0, delay_hard=0, inst_req stays 0.
//  5 Timeout: addr_ok, never data_ok; after TIMEOUT+1 cycles -> IADFE=1,
//    if_inst=0, delay_hard=0; late data_ok ignored.
//  6 Async reset mid-WAIT: outputs return to reset values at once; no stale fill afterwards.

Source files
------------

// File: rtl/inst_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_responder
// Purpose  : Instruction-side responder for the IF stage. Returns the
//            instruction for the current fetch pc from a one-entry buffer,
//            and on a miss fetches it over an SRAM-like bus. IF is held
//            with delay_hard while no valid instruction is available.
//            kseg0/kseg1 virtual addresses are translated to physical.
//            A misaligned pc raises IADEE; a bus timeout raises IADFE.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   1   rising-edge clock
//   reset         in   1   asynchronous, active-high reset
//   pc            in   32  fetch address from IF (virtual)
//   if_cln        in   1   pipeline clean: invalidate buffer, abandon fetch
//   if_inst       out  32  instruction for pc (valid when delay_hard==0)
//   delay_hard    out  1   no valid instruction for current pc; IF holds
//   IADEE         out  1   pc misaligned (combinational)
//   IADFE         out  1   fetch of current pc faulted (bus timeout)
//   inst_req      out  1   bus request
//   inst_addr     out  32  physical fetch address
//   inst_addr_ok  in   1   bus accepted the address this cycle
//   inst_data_ok  in   1   read data valid this cycle
//   inst_rdata    in   32  read data
// ============================================================================
module inst_fetch_responder #(
  parameter logic [31:0]      RESET_PC = 32'hbfc0_0000,
  parameter int unsigned      CNT_W    = 16,
  parameter logic [CNT_W-1:0] TIMEOUT  = CNT_W'(255)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        if_cln,
  output logic [31:0] if_inst,
  output logic        delay_hard,
  output logic        IADEE,
  output logic        IADFE,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE  = 2'd0;  // nothing outstanding
  localparam logic [1:0] ST_REQ   = 2'd1;  // request presented, no addr_ok yet
  localparam logic [1:0] ST_WAIT  = 2'd2;  // address accepted, awaiting data
  localparam logic [1:0] ST_DRAIN = 2'd3;  // awaiting data that will be dropped

  // kseg0 and kseg1 both map onto the low 512 MB of physical space.
  function automatic logic [31:0] f_phys(input logic [31:0] va);
    f_phys = (va[31:30] == 2'b10) ? {3'b000, va[28:0]} : va;
  endfunction

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic             r_buf_valid;
  logic [31:0]      r_buf_pc;
  logic [31:0]      r_buf_inst;
  logic             r_buf_fault;
  logic [31:0]      r_req_pc;
  logic             r_inst_req;
  logic [31:0]      r_inst_addr;
  logic [CNT_W-1:0] r_cnt;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic w_misaligned;
  logic w_hit;
  logic w_pc_moved;
  logic w_need_fetch;
  logic w_timeout;

  assign w_misaligned = (pc[1:0] != 2'b00);
  assign w_hit        = r_buf_valid && (r_buf_pc == pc);
  assign w_pc_moved   = (pc != r_req_pc);
  assign w_need_fetch = !w_hit && !w_misaligned && !if_cln;
  assign w_timeout    = (r_cnt == TIMEOUT);

  // --------------------------------------------------------------------------
  // IF-facing outputs. A misaligned pc never stalls IF: the address error
  // is reported immediately and the bus is left alone.
  // --------------------------------------------------------------------------
  always_comb begin
    if_inst    = 32'h0;
    delay_hard = 1'b0;
    IADEE      = 1'b0;
    IADFE      = 1'b0;
    if (w_misaligned) begin
      IADEE = 1'b1;
    end else begin
      if_inst    = w_hit ? r_buf_inst : 32'h0;
      delay_hard = !w_hit;
      IADFE      = w_hit && r_buf_fault;
    end
  end

  assign inst_req  = r_inst_req;
  assign inst_addr = r_inst_addr;

  // --------------------------------------------------------------------------
  // Fetch FSM and buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_buf_valid <= 1'b0;
      r_buf_pc    <= RESET_PC;
      r_buf_inst  <= 32'h0;
      r_buf_fault <= 1'b0;
      r_req_pc    <= RESET_PC;
      r_inst_req  <= 1'b0;
      r_inst_addr <= 32'h0;
      r_cnt       <= '0;
    end else begin
      // A clean invalidates the buffer in every state. No fill below can
      // coincide with if_cln, so there is no competing write.
      if (if_cln) begin
        r_buf_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_need_fetch) begin
            r_req_pc    <= pc;
            r_inst_addr <= f_phys(pc);
            r_inst_req  <= 1'b1;
            r_state     <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (inst_addr_ok) begin
            // The address on the bus was taken, so a transaction is now
            // outstanding whatever else happens; a simultaneous clean must
            // still wait for (and drop) its data.
            r_inst_req <= 1'b0;
            r_cnt      <= '0;
            r_state    <= if_cln ? ST_DRAIN : ST_WAIT;
          end else if (if_cln) begin
            r_inst_req <= 1'b0;
            r_state    <= ST_IDLE;
          end else if (w_pc_moved) begin
            if (w_misaligned || w_hit) begin
              // New pc needs no fetch: withdraw the unaccepted request.
              r_inst_req <= 1'b0;
              r_state    <= ST_IDLE;
            end else begin
              r_req_pc    <= pc;
              r_inst_addr <= f_phys(pc);
            end
          end
        end

        ST_WAIT: begin
          if (inst_data_ok) begin
            if (!w_pc_moved && !if_cln) begin
              r_buf_valid <= 1'b1;
              r_buf_pc    <= r_req_pc;
              r_buf_inst  <= inst_rdata;
              r_buf_fault <= 1'b0;
            end
            r_state <= ST_IDLE;
          end else if (w_pc_moved || if_cln) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_state <= ST_DRAIN;
          end else if (w_timeout) begin
            // Record the fault against the pc so IF can raise IADFE.
            r_buf_valid <= 1'b1;
            r_buf_pc    <= r_req_pc;
            r_buf_inst  <= 32'h0;
            r_buf_fault <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_DRAIN: begin
          // The counter keeps running so a bus that never answers cannot
          // lock the responder up; the abandoned data is then ignored in IDLE.
          if (inst_data_ok || (r_cnt >= TIMEOUT)) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
